vector_sequencer: RTL and testbench

//  Command-driven controller for vector_engine. Accepts one job (op, base address, depth), clears
//  the engine accumulators, streams `depth` rows of packed lane data from the trit frame buffer

---
 rtl/ternary_fabric_pkg.sv | 27 ++
 rtl/seq_feed_pipe.sv | 36 +++
 rtl/vector_sequencer.sv | 178 +++++++++++++++++
 tb/tb_vector_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_fabric_pkg.sv
// Shared types and constants for the ternary vector fabric.
// Op codes, trit encoding and sequencer state encoding.
package ternary_fabric_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_DOT = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/seq_feed_pipe.sv
// Two-stage valid/data pipe from frame-buffer read strobe to engine.
// Stage 1 tracks the read in flight, stage 2 registers the returned row.
module seq_feed_pipe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pending
);

  logic s1_valid;

  assign pending = s1_valid | out_valid;

  // Advance read-in-flight flag, then capture returned row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// Job sequencer: clears engine, streams rows, drains, reports done.
// One job at a time; abort returns to idle without completion.
module vector_sequencer
  import ternary_fabric_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_W    = 12,
  parameter int ENGINE_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [DEPTH_W-1:0] cmd_depth,
  input  logic               abort,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [LANES*2-1:0] rd_wdata,
  input  logic [LANES*2-1:0] rd_idata,
  output logic               ve_clear,
  output logic               ve_enable,
  output logic [2:0]         ve_op_mode,
  output logic [LANES*2-1:0] ve_weights,
  output logic [LANES*2-1:0] ve_inputs,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_err,
  output logic               busy
);

  localparam int DW    = LANES * 2;
  localparam int LAT_W = 8;

  seq_state_t         state, state_n;
  logic [ADDR_W-1:0]  base_q, base_n;
  logic [DEPTH_W-1:0] depth_q, depth_n;
  logic [DEPTH_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0]   lcnt, lcnt_n;
  logic [2:0]         op_n;
  logic               rd_en_n;
  logic [ADDR_W-1:0]  rd_addr_n;
  logic               clear_n;
  logic               res_valid_n;
  logic               res_err_n;
  logic               flush;
  logic               pend;
  logic [2*DW-1:0]    feed_data;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = (state == S_IDLE) & ~abort;

  seq_feed_pipe #(.W(2*DW)) u_feed (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (rd_en),
    .in_data  ({rd_wdata, rd_idata}),
    .out_valid(ve_enable),
    .out_data (feed_data),
    .pending  (pend)
  );

  assign ve_weights = feed_data[2*DW-1:DW];
  assign ve_inputs  = feed_data[DW-1:0];

  // Next-state and next registered-output decode.
  always_comb begin
    state_n     = state;
    base_n      = base_q;
    depth_n     = depth_q;
    cnt_n       = cnt;
    lcnt_n      = lcnt;
    op_n        = ve_op_mode;
    rd_en_n     = 1'b0;
    rd_addr_n   = rd_addr;
    clear_n     = 1'b0;
    res_valid_n = 1'b0;
    res_err_n   = 1'b0;
    flush       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n    = cmd_op;
          base_n  = cmd_base;
          depth_n = cmd_depth;
          clear_n = 1'b1;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!op_legal(ve_op_mode)) begin
          state_n     = S_DONE;
          res_valid_n = 1'b1;
          res_err_n   = 1'b1;
        end else if (depth_q == '0) begin
          state_n     = S_DONE;
          res_valid_n = 1'b1;
        end else begin
          state_n   = S_ISSUE;
          cnt_n     = DEPTH_W'(1);
          rd_en_n   = 1'b1;
          rd_addr_n = base_q;
        end
      end
      S_ISSUE: begin
        if (cnt == depth_q) begin
          state_n = S_DRAIN;
          lcnt_n  = '0;
        end else begin
          rd_en_n   = 1'b1;
          rd_addr_n = base_q + ADDR_W'(cnt);
          cnt_n     = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pend) begin
          if (lcnt == LAT_W'(ENGINE_LAT - 1)) begin
            state_n     = S_DONE;
            res_valid_n = 1'b1;
          end else begin
            lcnt_n = lcnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_n = S_IDLE;
        end else begin
          res_valid_n = 1'b1;
          res_err_n   = res_err;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n     = S_IDLE;
      rd_en_n     = 1'b0;
      clear_n     = 1'b0;
      res_valid_n = 1'b0;
      res_err_n   = 1'b0;
      flush       = 1'b1;
    end
    if (state_n == S_IDLE) op_n = '0;
  end

  // State, job fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      depth_q    <= '0;
      cnt        <= '0;
      lcnt       <= '0;
      ve_op_mode <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      ve_clear   <= 1'b0;
      res_valid  <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_n;
      base_q     <= base_n;
      depth_q    <= depth_n;
      cnt        <= cnt_n;
      lcnt       <= lcnt_n;
      ve_op_mode <= op_n;
      rd_en      <= rd_en_n;
      rd_addr    <= rd_addr_n;
      ve_clear   <= clear_n;
      res_valid  <= res_valid_n;
      res_err    <= res_err_n;
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer with a 1-cycle row RAM and a dot engine model.
// Expected completions are queued at issue and checked by a monitor.
module tb_vector_sequencer;
  import ternary_fabric_pkg::*;

  localparam int LANES      = 4;
  localparam int ADDR_W     = 16;
  localparam int DEPTH_W    = 12;
  localparam int ENGINE_LAT = 1;
  localparam int DW         = LANES * 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_base;
  logic [DEPTH_W-1:0] cmd_depth;
  logic               abort;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DW-1:0]      rd_wdata = '0;
  logic [DW-1:0]      rd_idata = '0;
  logic               ve_clear;
  logic               ve_enable;
  logic [2:0]         ve_op_mode;
  logic [DW-1:0]      ve_weights;
  logic [DW-1:0]      ve_inputs;
  logic               res_valid;
  logic               res_ready;
  logic               res_err;
  logic               busy;

  vector_sequencer #(
    .LANES(LANES), .ADDR_W(ADDR_W),
    .DEPTH_W(DEPTH_W), .ENGINE_LAT(ENGINE_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base),
    .cmd_depth(cmd_depth), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_wdata(rd_wdata), .rd_idata(rd_idata),
    .ve_clear(ve_clear), .ve_enable(ve_enable),
    .ve_op_mode(ve_op_mode), .ve_weights(ve_weights),
    .ve_inputs(ve_inputs), .res_valid(res_valid),
    .res_ready(res_ready), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Row RAM: every row returns the current weight/input patterns.
  logic [DW-1:0] wrow, irow;
  always @(posedge clk) begin
    if (rd_en) begin
      rd_wdata <= wrow;
      rd_idata <= irow;
    end
  end

  // Dot-product engine model fed by the sequencer outputs.
  function automatic int trit(input logic [1:0] t);
    if (t == TRIT_POS) return 1;
    if (t == TRIT_NEG) return -1;
    return 0;
  endfunction

  int acc [LANES];
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (ve_clear)
        acc[l] <= 0;
      else if (ve_enable && ve_op_mode == OP_DOT)
        acc[l] <= acc[l] + trit(ve_weights[2*l +: 2]) * trit(ve_inputs[2*l +: 2]);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   t0;
    int   lat;
    logic err;
    int   acc;
  } exp_t;

  exp_t sb [$];
  int   rd_log [$];
  int   en_cnt = 0;
  int   clr_cnt = 0;
  logic rv_q = 1'b0;
  exp_t mon_e;

  // Monitor: log reads/enables/clears, check each new completion.
  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(int'(rd_addr));
    if (ve_enable) en_cnt <= en_cnt + 1;
    if (ve_clear) clr_cnt <= clr_cnt + 1;
    if (res_valid && !rv_q) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("res_latency", cyc - mon_e.t0, mon_e.lat);
        check("res_err", res_err, mon_e.err);
        for (int l = 0; l < LANES; l++)
          check("lane_acc", acc[l], mon_e.acc);
      end
    end
    rv_q <= res_valid;
  end

  task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] base,
                       input int depth, input bit push, input int lat,
                       input bit err, input int a);
    exp_t e;
    @(negedge clk); #1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_depth = DEPTH_W'(depth);
    cmd_valid = 1'b1;
    #1;
    check("cmd_ready_at_issue", cmd_ready, 1);
    e.t0 = cyc; e.lat = lat; e.err = err; e.acc = a;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_ve_clear"}, ve_clear, 0);
    check({tag, "_ve_enable"}, ve_enable, 0);
    check({tag, "_ve_op_mode"}, ve_op_mode, 0);
    check({tag, "_ve_weights"}, ve_weights, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_err"}, res_err, 0);
  endtask

  int l0, e0, c0;
  int wrap_exp [4];

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_base = '0; cmd_depth = '0; abort = 1'b0;
    res_ready = 1'b1; wrow = 8'h55; irow = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Dot, base 0x10, depth 4, all +1
    l0 = rd_log.size(); e0 = en_cnt; c0 = clr_cnt;
    issue(OP_DOT, 16'h0010, 4, 1, 9, 0, 4);
    wait_idle();
    check("a_reads", rd_log.size() - l0, 4);
    for (int k = 0; k < 4; k++)
      check("a_rd_addr", rd_log[l0 + k], 16 + k);
    check("a_enables", en_cnt - e0, 4);
    check("a_clears", clr_cnt - c0, 1);

    // depth 0
    l0 = rd_log.size(); e0 = en_cnt; c0 = clr_cnt;
    issue(OP_DOT, 16'h0100, 0, 1, 2, 0, 0);
    wait_idle();
    check("z_reads", rd_log.size() - l0, 0);
    check("z_enables", en_cnt - e0, 0);
    check("z_clears", clr_cnt - c0, 1);

    // abort on third ISSUE cycle of depth 8
    l0 = rd_log.size();
    issue(OP_DOT, 16'h0040, 8, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    check("ab_pre_rd_en", rd_en, 1);
    abort = 1'b1;
    @(negedge clk); #1;
    check("ab_busy", busy, 0);
    check("ab_rd_en", rd_en, 0);
    check("ab_ve_enable", ve_enable, 0);
    check("ab_res_valid", res_valid, 0);
    check("ab_idle_blocks", cmd_ready, 0);
    abort = 1'b0;
    #1;
    check("ab_ready_back", cmd_ready, 1);
    check("ab_reads", rd_log.size() - l0, 3);

    // follow-up job: weights +1, inputs -1, depth 3
    irow = 8'hAA;
    l0 = rd_log.size();
    issue(OP_DOT, 16'h0020, 3, 1, 8, 0, -3);
    wait_idle();
    check("f_reads", rd_log.size() - l0, 3);
    check("f_first_addr", rd_log[l0], 16'h0020);

    // illegal op
    l0 = rd_log.size(); e0 = en_cnt;
    issue(3'b111, 16'h0030, 5, 1, 2, 1, 0);
    wait_idle();
    check("il_reads", rd_log.size() - l0, 0);
    check("il_enables", en_cnt - e0, 0);

    // completion held while res_ready low, cmd_valid kept high
    irow = 8'h55;
    res_ready = 1'b0;
    issue(OP_DOT, 16'h0050, 1, 1, 6, 0, 1);
    cmd_depth = DEPTH_W'(2);
    cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (res_valid) break;
      @(negedge clk); #1;
    end
    check("h_res_valid_seen", res_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("h_res_valid_held", res_valid, 1);
      check("h_cmd_ready_low", cmd_ready, 0);
      check("h_acc_stable", acc[0], 1);
      @(negedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    check("h_no_accept_on_handshake", cmd_ready, 0);
    begin
      exp_t e;
      @(negedge clk); #1;
      check("h_idle_after_handshake", busy, 0);
      check("h_second_ready", cmd_ready, 1);
      e.t0 = cyc; e.lat = 7; e.err = 1'b0; e.acc = 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    // address wrap
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    l0 = rd_log.size();
    issue(OP_DOT, 16'hFFFE, 4, 1, 9, 0, 4);
    wait_idle();
    check("w_reads", rd_log.size() - l0, 4);
    for (int k = 0; k < 4; k++)
      check("w_rd_addr", rd_log[l0 + k], wrap_exp[k]);

    // reset during ISSUE
    issue(OP_DOT, 16'h0200, 8, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("r_pre_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk); #1;
    check_quiet("midreset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
